// File: rtl/rob_pkg.sv
// Shared widths, types and default sizing for the ROB tag manager and its
// checkpoint table.
package rob_pkg;
  localparam int DEF_ROB_WIDTH  = 5;
  localparam int DEF_NUM_CKPT   = 4;
  localparam int DEF_CKPT_WIDTH = $clog2(DEF_NUM_CKPT);
  localparam int ROB_DEPTH      = 1 << DEF_ROB_WIDTH;

  typedef logic [DEF_ROB_WIDTH:0]    rob_ptr_t;
  typedef logic [DEF_ROB_WIDTH-1:0]  rob_tag_t;
  typedef logic [DEF_CKPT_WIDTH-1:0] ckpt_id_t;
endpackage

// File: rtl/rob_ckpt_table.sv
// Branch checkpoint table: one tail snapshot per in-flight branch, valid bits,
// allocation pointer and the younger-mask used to squash on a mispredict.
module rob_ckpt_table
  import rob_pkg::*;
#(
  parameter int NUM_CKPT   = DEF_NUM_CKPT,
  parameter int CKPT_WIDTH = $clog2(NUM_CKPT),
  parameter int PTR_WIDTH  = DEF_ROB_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  branch_gnt,
  input  logic [PTR_WIDTH-1:0]  snap_in,
  input  logic                  resolve_ok,
  input  logic [CKPT_WIDTH-1:0] resolve_id,
  input  logic                  flush,
  output logic [CKPT_WIDTH-1:0] ckpt_ptr,
  output logic                  ckpt_avail,
  output logic                  resolve_hit,
  output logic [PTR_WIDTH-1:0]  restore_ptr
);
  logic [PTR_WIDTH-1:0]  snap [NUM_CKPT];
  logic [NUM_CKPT-1:0]   valid;
  logic [NUM_CKPT-1:0]   younger;
  logic [CKPT_WIDTH-1:0] span;

  assign ckpt_avail  = ~valid[ckpt_ptr];
  assign resolve_hit = valid[resolve_id];
  assign restore_ptr = snap[resolve_id];
  assign span        = ckpt_ptr - resolve_id;

  // span==0 with a valid resolving id means the table wrapped fully: squash all
  always_comb begin
    younger = '0;
    for (int i = 0; i < NUM_CKPT; i++) begin
      younger[i] = (span == '0) || ((CKPT_WIDTH'(i) - resolve_id) < span);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid    <= '0;
      ckpt_ptr <= '0;
    end else if (flush) begin
      valid    <= valid & ~younger;
      ckpt_ptr <= resolve_id;
    end else begin
      if (resolve_ok) valid[resolve_id] <= 1'b0;
      if (branch_gnt) begin
        valid[ckpt_ptr] <= 1'b1;
        ckpt_ptr        <= ckpt_ptr + {{(CKPT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (branch_gnt && !flush) snap[ckpt_ptr] <= snap_in;
  end
endmodule

// File: rtl/rob_tag_manager.sv
// ROB tag allocator: head/tail pointers with wrap bit, occupancy flags and
// dispatch grant; branch checkpoints live in rob_ckpt_table.
module rob_tag_manager
  import rob_pkg::*;
#(
  parameter int ROB_WIDTH  = DEF_ROB_WIDTH,
  parameter int NUM_CKPT   = DEF_NUM_CKPT,
  parameter int CKPT_WIDTH = $clog2(NUM_CKPT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alloc_req,
  input  logic                  is_branch_dispatch,
  output logic                  alloc_gnt,
  output logic [ROB_WIDTH-1:0]  rob_tag,
  output logic [CKPT_WIDTH-1:0] ckpt_id,
  input  logic                  retire_valid,
  input  logic                  branch_resolve,
  input  logic [CKPT_WIDTH-1:0] resolve_ckpt_id,
  input  logic                  branch_mispredict,
  output logic                  full,
  output logic                  empty,
  output logic [ROB_WIDTH:0]    count,
  output logic                  ckpt_avail
);
  localparam logic [ROB_WIDTH:0] ONE   = {{ROB_WIDTH{1'b0}}, 1'b1};
  localparam logic [ROB_WIDTH:0] DEPTH = {1'b1, {ROB_WIDTH{1'b0}}};

  logic [ROB_WIDTH:0] head, tail, tail_inc, restore_ptr;
  logic               resolve_hit, flush;

  assign tail_inc  = tail + ONE;
  assign count     = tail - head;
  assign full      = (count == DEPTH);
  assign empty     = (count == '0);
  assign rob_tag   = tail[ROB_WIDTH-1:0];
  assign flush     = branch_resolve & branch_mispredict & resolve_hit;
  assign alloc_gnt = alloc_req & ~full & ~flush & (~is_branch_dispatch | ckpt_avail);

  rob_ckpt_table #(
    .NUM_CKPT  (NUM_CKPT),
    .CKPT_WIDTH(CKPT_WIDTH),
    .PTR_WIDTH (ROB_WIDTH + 1)
  ) u_ckpt (
    .clk        (clk),
    .reset      (reset),
    .branch_gnt (alloc_gnt & is_branch_dispatch),
    .snap_in    (tail_inc),
    .resolve_ok (branch_resolve & ~branch_mispredict),
    .resolve_id (resolve_ckpt_id),
    .flush      (flush),
    .ckpt_ptr   (ckpt_id),
    .ckpt_avail (ckpt_avail),
    .resolve_hit(resolve_hit),
    .restore_ptr(restore_ptr)
  );

  // Retire applies alongside a flush: the retiring entry predates every branch
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (flush)          tail <= restore_ptr;
      else if (alloc_gnt) tail <= tail_inc;
      if (retire_valid && !empty) head <= head + ONE;
    end
  end
endmodule

// File: tb/tb_rob_tag_manager.sv
// Bench for rob_tag_manager: directed scenarios plus random traffic against a
// sequence-number/age-stamp reference model.
module tb_rob_tag_manager;
  localparam int RW = 5;
  localparam int NC = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          alloc_req, is_branch_dispatch, alloc_gnt;
  logic [RW-1:0] rob_tag;
  logic [CW-1:0] ckpt_id, resolve_ckpt_id;
  logic          retire_valid, branch_resolve, branch_mispredict;
  logic          full, empty, ckpt_avail;
  logic [RW:0]   count;

  rob_tag_manager #(.ROB_WIDTH(RW), .NUM_CKPT(NC), .CKPT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .alloc_req(alloc_req),
    .is_branch_dispatch(is_branch_dispatch), .alloc_gnt(alloc_gnt),
    .rob_tag(rob_tag), .ckpt_id(ckpt_id), .retire_valid(retire_valid),
    .branch_resolve(branch_resolve), .resolve_ckpt_id(resolve_ckpt_id),
    .branch_mispredict(branch_mispredict), .full(full), .empty(empty),
    .count(count), .ckpt_avail(ckpt_avail)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pointers mod 2*depth, checkpoints ordered by age stamp
  int m_head, m_tail, m_ptr, m_stamp_ctr;
  bit m_valid [NC];
  int m_snap  [NC];
  int m_stamp [NC];
  int obs_gnt, obs_tag, obs_count, obs_avail, obs_cid, obs_empty, obs_full;

  task automatic model_reset();
    m_head = 0; m_tail = 0; m_ptr = 0; m_stamp_ctr = 0;
    for (int j = 0; j < NC; j++) begin
      m_valid[j] = 1'b0; m_snap[j] = 0; m_stamp[j] = 0;
    end
  endtask

  function automatic bit head_is_branch();
    for (int j = 0; j < NC; j++)
      if (m_valid[j] && (((m_snap[j] - 1 - m_head) & 63) == 0)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cyc(input bit req, input bit br, input bit ret,
                     input bit res, input bit mis, input int rid);
    int cnt, stamp_k;
    bit e_full, e_empty, avail, fl, g;
    alloc_req = req; is_branch_dispatch = br; retire_valid = ret;
    branch_resolve = res; branch_mispredict = mis; resolve_ckpt_id = rid[CW-1:0];
    @(negedge clk);
    cnt     = (m_tail - m_head) & 63;
    e_full  = (cnt == 32);
    e_empty = (cnt == 0);
    avail   = !m_valid[m_ptr];
    fl      = res && mis && m_valid[rid];
    g       = req && !e_full && !fl && (!br || avail);
    check("alloc_gnt",  int'(alloc_gnt),  int'(g));
    check("rob_tag",    int'(rob_tag),    m_tail & 31);
    check("ckpt_id",    int'(ckpt_id),    m_ptr);
    check("ckpt_avail", int'(ckpt_avail), int'(avail));
    check("full",       int'(full),       int'(e_full));
    check("empty",      int'(empty),      int'(e_empty));
    check("count",      int'(count),      cnt);
    obs_gnt = alloc_gnt; obs_tag = rob_tag; obs_count = count;
    obs_avail = ckpt_avail; obs_cid = ckpt_id; obs_empty = empty; obs_full = full;
    @(posedge clk);
    if (fl) begin
      stamp_k = m_stamp[rid];
      for (int j = 0; j < NC; j++)
        if (m_valid[j] && m_stamp[j] >= stamp_k) m_valid[j] = 1'b0;
      m_tail = m_snap[rid];
      m_ptr  = rid;
    end else begin
      if (res && !mis) m_valid[rid] = 1'b0;
      if (g) begin
        if (br) begin
          m_stamp_ctr++;
          m_snap[m_ptr]  = (m_tail + 1) & 63;
          m_valid[m_ptr] = 1'b1;
          m_stamp[m_ptr] = m_stamp_ctr;
          m_ptr          = (m_ptr + 1) % NC;
        end
        m_tail = (m_tail + 1) & 63;
      end
    end
    if (ret && !e_empty) m_head = (m_head + 1) & 63;
    #1;
  endtask

  // Reset with busy inputs: reset must override everything
  task automatic do_reset();
    reset = 1'b1;
    alloc_req = 1'b1; is_branch_dispatch = 1'b1; retire_valid = 1'b1;
    branch_resolve = 1'b1; branch_mispredict = 1'b1; resolve_ckpt_id = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic branch_seq(input int rid);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, rid);
  endtask

  initial begin
    model_reset();
    do_reset();

    // fill to full, then blocked requests, then wrap to tag 0
    cyc(0, 0, 0, 0, 0, 0);
    check("rst_empty", obs_empty, 1);
    check("rst_avail", obs_avail, 1);
    for (int i = 0; i < 32; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      check("fill_tag", obs_tag, i);
    end
    cyc(1, 0, 0, 0, 0, 0);
    check("full_gnt", obs_gnt, 0);
    check("full_cnt", obs_count, 32);
    cyc(1, 0, 1, 0, 0, 0);
    check("full_ret_gnt", obs_gnt, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("after_ret_gnt", obs_gnt, 1);
    check("after_ret_tag", obs_tag, 0);

    // mispredict oldest checkpoint
    branch_seq(0);
    cyc(1, 0, 0, 0, 0, 0);
    check("mp0_tag", obs_tag, 4);
    check("mp0_cid", obs_cid, 0);
    check("mp0_avail", obs_avail, 1);

    // mispredict younger checkpoint; older one must survive
    branch_seq(1);
    cyc(0, 0, 0, 0, 0, 0);
    check("mp1_tag", obs_tag, 8);
    check("mp1_cid", obs_cid, 1);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("mp1_ck0_kept", obs_tag, 4);

    // checkpoint table exhaustion
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    check("ckfull_br_gnt", obs_gnt, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("ckfull_nb_gnt", obs_gnt, 1);
    cyc(0, 0, 0, 1, 0, 2);
    cyc(0, 0, 0, 0, 0, 0);
    check("ckfull_avail", obs_avail, 0);

    // snapshot restore across the wrap
    do_reset();
    for (int i = 0; i < 30; i++) cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    check("wrap_br_tag", obs_tag, 31);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("wrap_tag", obs_tag, 0);
    check("wrap_cnt", obs_count, 2);

    // mispredict + retire + alloc in one cycle
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 1, 0);
    check("combo_gnt", obs_gnt, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("combo_tag", obs_tag, 1);
    check("combo_cnt", obs_count, 2);

    // reset mid-stream
    cyc(1, 1, 0, 0, 0, 0);
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    check("midrst_gnt", obs_gnt, 1);
    check("midrst_tag", obs_tag, 0);
    check("midrst_cnt", obs_count, 0);

    // random traffic; head never retires past an unresolved branch
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit req, br, ret, res, mis;
      int rid;
      req = ($urandom_range(0, 9) < 7);
      br  = ($urandom_range(0, 3) == 0);
      ret = ($urandom_range(0, 2) == 0) && !head_is_branch();
      res = ($urandom_range(0, 3) == 0);
      mis = ($urandom_range(0, 3) == 0);
      rid = $urandom_range(0, NC - 1);
      cyc(req, br, ret, res, mis, rid);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rob_tag_manager.md
# rob_tag_manager

Parametrised ROB tag allocator with multi-level branch checkpointing, occupancy tracking and in-order retirement. It sits between dispatch and the ROB. It hands out tags in program order and stalls dispatch when the ROB or the checkpoint table is full. It keeps one tail snapshot per in-flight branch, so a mispredict on any unresolved branch restores the allocation pointer in one cycle, not just the most recent branch.

## Interface
Clock `clk`; reset `reset` is synchronous, active-high.

Parameters:
- `ROB_WIDTH`, 5: tag width; ROB depth = 2^ROB_WIDTH
- `NUM_CKPT`, 4: number of branch checkpoints (power of two, ≥2)
- `CKPT_WIDTH`, $clog2(NUM_CKPT): checkpoint id width

Ports:
- `clk` in 1: clock
- `reset` in 1: synchronous active-high reset
- `alloc_req` in 1: dispatch requests one tag
- `is_branch_dispatch` in 1: the requesting instruction is a branch and needs a checkpoint
- `alloc_gnt` out 1: request accepted this cycle
- `rob_tag` out ROB_WIDTH: tag for the current request (tail low bits)
- `ckpt_id` out CKPT_WIDTH: checkpoint id assigned if a branch is granted
- `retire_valid` in 1: oldest ROB entry retires
- `branch_resolve` in 1: a branch resolved
- `resolve_ckpt_id` in CKPT_WIDTH: checkpoint of the resolving branch
- `branch_mispredict` in 1: qualifies `branch_resolve` as a mispredict
- `full` out 1, `empty` out 1: ROB occupancy flags
- `count` out ROB_WIDTH+1: occupied entries
- `ckpt_avail` out 1: a free checkpoint exists at `ckpt_id`

## Operation
- `head` and `tail` are ROB_WIDTH+1 bits wide (wrap bit + index); `count = tail - head` modulo 2^(ROB_WIDTH+1).
- `full` when `count == 2^ROB_WIDTH`; `empty` when `count == 0`.
- `flush = branch_resolve & branch_mispredict & ckpt_valid[resolve_ckpt_id]`.
- `alloc_gnt = alloc_req & !full & !flush & (!is_branch_dispatch | ckpt_avail)`. The grant is combinational from registered state and current inputs.
- On grant, `tail` increments by 1.
- On a branch grant:
  - `snap[ckpt_ptr] <= tail + 1`, so the snapshot holds the pointer after the branch's own entry.
  - `ckpt_valid[ckpt_ptr] <= 1`; `ckpt_ptr` increments modulo NUM_CKPT.
  - `ckpt_id = ckpt_ptr[CKPT_WIDTH-1:0]`; `ckpt_avail = !ckpt_valid[ckpt_ptr]`.
- Correct resolve (`branch_resolve & !branch_mispredict`): clear `ckpt_valid[resolve_ckpt_id]`. Out-of-order resolution is allowed.
- Mispredict (`flush`):
  - `tail <= snap[resolve_ckpt_id]`.
  - Clear `ckpt_valid` for `resolve_ckpt_id` and every younger id, i.e. circularly from `resolve_ckpt_id` up to `ckpt_ptr-1`.
  - `ckpt_ptr <= resolve_ckpt_id`.
- Retire: if `retire_valid & !empty`, `head` increments. Retire while empty is ignored.
- `branch_resolve` for an id whose valid bit is clear is ignored; no state changes.

## Timing
- Reset values: head=tail=0, count=0, empty=1, full=0, rob_tag=0, ckpt_ptr=0, ckpt_id=0, all ckpt_valid=0, ckpt_avail=1, alloc_gnt follows its equation (=alloc_req).
- All state updates on the rising edge, one cycle after inputs. Outputs are combinational from registers with zero-cycle grant latency.
- Simultaneous events:
  - Mispredict + alloc: mispredict wins, `alloc_gnt=0`.
  - Mispredict + retire: both apply; the retired entry is older than any branch.
  - Alloc + retire when full: no grant (full is evaluated pre-edge).
  - Alloc + retire otherwise: count unchanged.
- Wrap-around: the index wraps at 2^ROB_WIDTH and the wrap bit toggles. A snapshot restore across the wrap must give the correct count.
- Reset asserted mid-operation clears everything the next edge and overrides all other inputs.

## Structure
- Shared package `rob_pkg`: `rob_ptr_t` (ROB_WIDTH+1 bits), `rob_tag_t`, `ckpt_id_t`, and constant `ROB_DEPTH`.
- One sub-module, `rob_ckpt_table`: snapshot array, valid vector, `ckpt_ptr`, and the younger-mask generation for mispredict.
- The top level holds the head/tail pointers, flags and grant logic.

## Test plan
- Reset, then alloc 32 cycles with ROB_WIDTH=5 → tags 0..31, `full=1`, `count=32`. The 33rd request gets `alloc_gnt=0`. One retire with the same-cycle alloc still gives no grant; next cycle grants tag 0.
- Branch at tag 3 (ckpt 0), allocs 4..6, branch at tag 7 (ckpt 1), allocs 8..9; mispredict ckpt 0 → next `rob_tag=4`, both checkpoints free, `ckpt_id=0`.
- Same sequence, mispredict ckpt 1 → next `rob_tag=8`, ckpt 0 still valid, `ckpt_id=1`.
- Dispatch 4 branches (NUM_CKPT=4) with no resolve → 5th branch request gets `alloc_gnt=0`. A non-branch request the same cycle is granted. Correctly resolving ckpt 2 still leaves `ckpt_avail=0` (ptr at 0 is valid).
- Head/tail at 30, branch at tag 31 spans the wrap, allocs 0..2; mispredict → `rob_tag=0`, `count=2`.
- Mispredict + retire + alloc in one cycle → tail restored, head+1, `alloc_gnt=0`. Then reset asserted mid-stream → all reset values next cycle.
